// File: rtl/lpc_pkg.sv
// Shared LPC definitions used by both the host-side initiator and the target.
// Cycle types, SYNC/START/TAR nibble codes, target states and decode helper.
package lpc_pkg;

  typedef enum logic [1:0] {
    CT_IO  = 2'b00,
    CT_MEM = 2'b01,
    CT_DMA = 2'b10
  } cyc_type_e;

  localparam logic [3:0] LAD_START  = 4'b0000;
  localparam logic [3:0] LAD_TAR    = 4'b1111;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTDIR,
    ST_ADDR,
    ST_WDATA,
    ST_HTAR,
    ST_SYNC,
    ST_RDATA,
    ST_TTAR,
    ST_IGNORE
  } tgt_state_e;

  function automatic logic addr_hit(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] mask
  );
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// Nibble capture register: shifts LAD nibbles in at the bottom, MSB first.
// nxt exposes the value including the nibble being sampled this edge.
module lpc_nibble_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [3:0]  nib,
  output logic [31:0] nxt,
  output logic [2:0]  cnt
);

  logic [27:0] q;

  assign nxt = {q, nib};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (shift) begin
      q   <= nxt[27:0];
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/lpc_target.sv
// LPC memory-cycle target bridging single-byte reads/writes to a req/ack port.
// Define LPC_TARGET_SYNC_ERR_EN to time out long-wait SYNC with an error code.
module lpc_target
  import lpc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF00_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFF00_0000
`ifdef LPC_TARGET_SYNC_ERR_EN
  ,
  parameter int WAIT_MAX = 16
`endif
) (
  input  logic        lclk,
  input  logic        lreset,
  input  logic [3:0]  lad_in,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic        lframe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  tgt_state_e state, state_n;

  logic        dir_q, dir_n;
  logic        htar_q, rd_q;
  logic [31:0] addr_cap;
  logic [7:0]  rdata_q;
  logic        ack_flag, discard, launch_q;
  logic [31:0] pend_addr;
  logic        pend_we;
  logic [7:0]  pend_wdata;

  logic        oe_n;
  logic [3:0]  out_n;
  logic        sh_clr, sh_shift, cap_addr;
  logic [31:0] sh_nxt;
  logic [2:0]  sh_cnt;
  logic        launch_now, launch_we;
  logic [31:0] launch_addr;
  logic [7:0]  launch_wdata;
  logic        err_now, wait_hit, ready_now;

  lpc_nibble_shift u_shift (
    .clk   (lclk),
    .rst   (lreset),
    .clr   (sh_clr),
    .shift (sh_shift),
    .nib   (lad_in),
    .nxt   (sh_nxt),
    .cnt   (sh_cnt)
  );

  // An ack for a discarded request must never look like ours.
  assign ready_now = ack_flag | (mem_req & mem_ack & ~discard);

`ifdef LPC_TARGET_SYNC_ERR_EN
  localparam int WW = $clog2(WAIT_MAX + 1);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge lclk or posedge lreset) begin
    if (lreset) begin
      wait_cnt <= '0;
    end else if (state != ST_SYNC) begin
      wait_cnt <= WW'(1);
    end else if (out_n == SYNC_LWAIT) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign wait_hit = (wait_cnt == WW'(WAIT_MAX));
`else
  assign wait_hit = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    dir_n        = dir_q;
    oe_n         = 1'b0;
    out_n        = LAD_TAR;
    sh_clr       = 1'b0;
    sh_shift     = 1'b0;
    cap_addr     = 1'b0;
    launch_now   = 1'b0;
    launch_we    = 1'b0;
    launch_addr  = sh_nxt;
    launch_wdata = 8'h00;
    err_now      = 1'b0;
    if (!lframe) begin
      state_n = (lad_in == LAD_START) ? ST_CTDIR : ST_IDLE;
      sh_clr  = 1'b1;
    end else begin
      unique case (state)
        ST_CTDIR: begin
          if (lad_in[3:2] == CT_MEM) begin
            state_n = ST_ADDR;
            dir_n   = lad_in[1];
          end else begin
            state_n = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          sh_shift = 1'b1;
          if (sh_cnt == 3'd7) begin
            cap_addr = 1'b1;
            if (!addr_hit(sh_nxt, BASE_ADDR, ADDR_MASK)) begin
              state_n = ST_IGNORE;
            end else if (dir_q) begin
              state_n = ST_WDATA;
            end else begin
              state_n    = ST_HTAR;
              launch_now = 1'b1;
            end
          end
        end
        ST_WDATA: begin
          sh_shift = 1'b1;
          if (sh_cnt == 3'd1) begin
            state_n      = ST_HTAR;
            launch_now   = 1'b1;
            launch_we    = 1'b1;
            launch_addr  = addr_cap;
            launch_wdata = {sh_nxt[3:0], sh_nxt[7:4]};
          end
        end
        ST_HTAR: begin
          if (htar_q) begin
            state_n = ST_SYNC;
            oe_n    = 1'b1;
            out_n   = ready_now ? SYNC_READY : SYNC_LWAIT;
          end
        end
        ST_SYNC: begin
          oe_n = 1'b1;
          if (lad_out == SYNC_READY) begin
            state_n = dir_q ? ST_TTAR : ST_RDATA;
            out_n   = dir_q ? LAD_TAR : rdata_q[3:0];
          end else if (lad_out == SYNC_ERROR) begin
            state_n = ST_TTAR;
          end else if (ready_now) begin
            out_n = SYNC_READY;
          end else if (wait_hit) begin
            out_n   = SYNC_ERROR;
            err_now = 1'b1;
          end else begin
            out_n = SYNC_LWAIT;
          end
        end
        ST_RDATA: begin
          oe_n = 1'b1;
          if (!rd_q) begin
            out_n = rdata_q[7:4];
          end else begin
            state_n = ST_TTAR;
          end
        end
        ST_TTAR: state_n = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge lclk or posedge lreset) begin
    if (lreset) begin
      state    <= ST_IDLE;
      lad_oe   <= 1'b0;
      lad_out  <= LAD_TAR;
      dir_q    <= 1'b0;
      htar_q   <= 1'b0;
      rd_q     <= 1'b0;
      addr_cap <= '0;
    end else begin
      state   <= state_n;
      lad_oe  <= oe_n;
      lad_out <= out_n;
      dir_q   <= dir_n;
      htar_q  <= (state == ST_HTAR) && lframe && !htar_q;
      rd_q    <= (state == ST_RDATA) && lframe && !rd_q;
      if (cap_addr) addr_cap <= sh_nxt;
    end
  end

  // A new request waits in pend_* while an abandoned one is still out.
  always_ff @(posedge lclk or posedge lreset) begin
    if (lreset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_q    <= '0;
      ack_flag   <= 1'b0;
      discard    <= 1'b0;
      launch_q   <= 1'b0;
      pend_addr  <= '0;
      pend_we    <= 1'b0;
      pend_wdata <= '0;
    end else begin
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        discard <= 1'b0;
        if (!discard) begin
          ack_flag <= 1'b1;
          rdata_q  <= mem_rdata;
        end
      end else if (mem_req && (!lframe || err_now)) begin
        discard <= 1'b1;
      end
      if (launch_now) begin
        ack_flag <= 1'b0;
        if (!mem_req) begin
          mem_req   <= 1'b1;
          mem_we    <= launch_we;
          mem_addr  <= launch_addr;
          mem_wdata <= launch_wdata;
        end else begin
          launch_q   <= 1'b1;
          pend_addr  <= launch_addr;
          pend_we    <= launch_we;
          pend_wdata <= launch_wdata;
        end
      end else if (launch_q && !mem_req) begin
        mem_req   <= 1'b1;
        mem_we    <= pend_we;
        mem_addr  <= pend_addr;
        mem_wdata <= pend_wdata;
        launch_q  <= 1'b0;
        ack_flag  <= 1'b0;
      end
      if (!lframe || err_now) launch_q <= 1'b0;
    end
  end

endmodule

// File: doc/lpc_target.md
Name: lpc_target

Overview:
- LPC memory-cycle responder: the peripheral end of the LPC link driven by our host-side LPC initiator.
- Decodes START, CYCTYPE/DIR, address and write data from LAD, then drives SYNC, read data and turnaround.
- Converts each matched cycle into one req/ack transaction on a simple local memory port (ROM/SRAM/register backend).
- Supports single-byte memory reads and writes only.

Parameters:
- BASE_ADDR, 32'hFF00_0000, decode base; match when (addr & ADDR_MASK) == BASE_ADDR.
- ADDR_MASK, 32'hFF00_0000, decode mask.
- WAIT_MAX, 16, max lclk cycles in SYNC before error (used only with the optional feature).

Ports:
- lclk  in  1  LPC clock; all logic on posedge.
- lreset  in  1  asynchronous, active-high reset.
- lad_in  in  4  LAD sampled value.
- lad_out  out  4  LAD drive value.
- lad_oe  out  1  LAD output enable.
- lframe  in  1  LFRAME, active low.
- mem_req  out  1  local request, level-held until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  captured address.
- mem_wdata  out  8  captured write byte.
- mem_rdata  in  8  read byte, valid with mem_ack.
- mem_ack  in  1  one-cycle completion.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, lad_oe=0, lad_out=4'hF, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, internal ack flag cleared.
- All outputs are registered.
- START: any edge with lframe=0 and lad_in=0000 enters CTDIR. Holding lframe low restarts every cycle; the nibble after the last lframe-low cycle is CTDIR.
- CTDIR nibble {type[1:0], dir, x}:
  - type=01: accept; dir=1 write, 0 read.
  - Any other type: go to IGNORE.
- ADDR: 8 nibbles, MSB first (addr[31:28] first). After the last nibble, check the decode window; a miss goes to IGNORE.
- IGNORE: never drives LAD; waits for the next START.
- Write path: ADDR, WDATA (2 nibbles, low nibble first), HTAR (2 cycles, target not driving), SYNC, TTAR.
- Read path: ADDR, HTAR (2 cycles), SYNC, RDATA (2 nibbles, low nibble first), TTAR.
- mem_req timing:
  - Asserts on the edge after the last address nibble (read) or the last data nibble (write).
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - Clears on the edge where mem_ack=1 is sampled, which also sets the ack flag and latches mem_rdata.
  - mem_ack while mem_req=0 is ignored.
- SYNC: lad_oe=1 starting the cycle after the second HTAR cycle. Drive 0110 (long wait) while the ack flag is clear, then 0000 for exactly one cycle once set. Ready can appear in the first SYNC cycle if ack arrived during HTAR.
- RDATA: drive rdata[3:0], then rdata[7:4].
- TTAR: drive 1111 for one cycle, then lad_oe=0 and return to IDLE.
- Abort (lframe=0 in any non-IDLE state):
  - Release LAD (lad_oe=0) on the next edge.
  - Treat the cycle as a START candidate.
  - An outstanding mem_req stays asserted until ack, then its result is discarded; a new cycle's mem_req is not raised until then.
- Reset mid-cycle: immediate return to reset values; the backend must tolerate a dropped request.

Optional Feature:
- Macro LPC_TARGET_SYNC_ERR_EN.
- Defined: a counter runs from SYNC entry. If WAIT_MAX cycles pass without ack, drive SYNC 1010 (error) for one cycle, then TTAR; skip RDATA. The request remains pending and is discarded at ack, as for abort.
- Undefined: long wait continues indefinitely and no counter is synthesized.

Decomposition:
- Shared package lpc_pkg:
  - Cycle-type codes (IO=00, MEMORY=01, DMA=10).
  - SYNC codes (READY=0000, SWAIT=0101, LWAIT=0110, ERROR=1010).
  - START=0000, TAR=1111.
  - Target state enum.
- Host and target both use the package.
- One sub-module, lpc_nibble_shift: a 32-bit nibble shift/capture register with a count, used for address and data capture.

Test Plan:
- Read, BASE match: host read at 0xFF001234, backend acks 3 cycles after req with 0xA5 -> mem_addr=0xFF001234, mem_we=0; SYNC shows 0110 until ack, then 0000; LAD shows 5 then A; 1111; then released.
- Write, zero-wait: write 0x3C to 0xFF000010, ack on the same cycle req rises -> mem_wdata=0x3C, mem_we=1; first SYNC nibble is 0000; TTAR 1111; lad_oe=0.
- Decode miss: read at 0x00001000 -> mem_req never asserts, lad_oe stays 0 for the whole cycle.
- Abort: lframe=0 with LAD=0000 during ADDR nibble 5 -> lad_oe=0; next full read at 0xFF000004 completes normally.
- Non-memory CTDIR 0000 (IO) -> IGNORE, no drive, no request.
- With LPC_TARGET_SYNC_ERR_EN and WAIT_MAX=16, backend never acks -> 16 cycles of 0110, then 1010, then 1111, then release; a late ack is ignored.
